// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accepts one ALU command at a time, waits a settle time, then holds the result for the display path.
// Build option ALU_SEQ_DIV0_EN: a divide by zero goes straight to HOLD with res_err set.

module alu_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [1:0]  DIV_CODE      = 2'd3
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opa,
  input  logic [3:0] cmd_opb,
  input  logic       cmd_signa,
  input  logic       cmd_signb,
  input  logic [1:0] cmd_asm,

  output logic [3:0] alu_opa,
  output logic [3:0] alu_opb,
  output logic       alu_signa,
  output logic       alu_signb,
  output logic [1:0] alu_asm,
  input  logic [7:0] alu_opc,
  input  logic       alu_signc,

  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_opc,
  output logic       res_sign,
  output logic       res_err,

  output logic       busy,
  output logic [7:0] op_count
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ASM_W = 2;
  localparam int unsigned RES_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPC_W = 8;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  // Settle counter is CNT_W bits wide, so only 1..15 is meaningful.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DIV_CODE > 2'd3) begin : g_bad_param
    $error("alu_seq_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [OP_W-1:0]    alu_opa_q,   alu_opa_d;
  logic [OP_W-1:0]    alu_opb_q,   alu_opb_d;
  logic               alu_signa_q, alu_signa_d;
  logic               alu_signb_q, alu_signb_d;
  logic [ASM_W-1:0]   alu_asm_q,   alu_asm_d;
  logic [RES_W-1:0]   res_opc_q,   res_opc_d;
  logic               res_sign_q,  res_sign_d;
  logic [OPC_W-1:0]   op_count_q,  op_count_d;
`ifdef ALU_SEQ_DIV0_EN
  logic               res_err_q,   res_err_d;
  logic               div0_q,      div0_d;
`endif

  // Next-state and datapath load decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_opa_d   = alu_opa_q;
    alu_opb_d   = alu_opb_q;
    alu_signa_d = alu_signa_q;
    alu_signb_d = alu_signb_q;
    alu_asm_d   = alu_asm_q;
    res_opc_d   = res_opc_q;
    res_sign_d  = res_sign_q;
    op_count_d  = op_count_q;
`ifdef ALU_SEQ_DIV0_EN
    res_err_d   = res_err_q;
    div0_d      = div0_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_opa_d   = cmd_opa;
          alu_opb_d   = cmd_opb;
          alu_signa_d = cmd_signa;
          alu_signb_d = cmd_signb;
          alu_asm_d   = cmd_asm;
          cnt_d       = '0;
`ifdef ALU_SEQ_DIV0_EN
          div0_d      = (cmd_asm == DIV_CODE) && (cmd_opb == OP_W'(0));
`endif
          state_d     = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_SEQ_DIV0_EN
        // Divide by zero never waits on the ALU; its result is fixed.
        if (div0_q) begin
          res_opc_d  = '0;
          res_sign_d = 1'b0;
          res_err_d  = 1'b1;
          state_d    = ST_HOLD;
        end else
`endif
        if (cnt_d == SETTLE_LAST) begin
          res_opc_d  = alu_opc;
          res_sign_d = alu_signc;
`ifdef ALU_SEQ_DIV0_EN
          res_err_d  = 1'b0;
`endif
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          op_count_d = op_count_q + OPC_W'(1);
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_opa_q   <= '0;
      alu_opb_q   <= '0;
      alu_signa_q <= 1'b0;
      alu_signb_q <= 1'b0;
      alu_asm_q   <= '0;
      res_opc_q   <= '0;
      res_sign_q  <= 1'b0;
      op_count_q  <= '0;
`ifdef ALU_SEQ_DIV0_EN
      res_err_q   <= 1'b0;
      div0_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_opa_q   <= alu_opa_d;
      alu_opb_q   <= alu_opb_d;
      alu_signa_q <= alu_signa_d;
      alu_signb_q <= alu_signb_d;
      alu_asm_q   <= alu_asm_d;
      res_opc_q   <= res_opc_d;
      res_sign_q  <= res_sign_d;
      op_count_q  <= op_count_d;
`ifdef ALU_SEQ_DIV0_EN
      res_err_q   <= res_err_d;
      div0_q      <= div0_d;
`endif
    end
  end

  // Handshake flags decode straight from the state register.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);

  assign alu_opa   = alu_opa_q;
  assign alu_opb   = alu_opb_q;
  assign alu_signa = alu_signa_q;
  assign alu_signb = alu_signb_q;
  assign alu_asm   = alu_asm_q;
  assign res_opc   = res_opc_q;
  assign res_sign  = res_sign_q;
  assign op_count  = op_count_q;

`ifdef ALU_SEQ_DIV0_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed table, multi-cycle corner sequences, randomized ops, op_count wrap.

module tb_alu_seq_ctrl;

  localparam int unsigned S = 2;
`ifdef ALU_SEQ_DIV0_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_opa, cmd_opb;
  logic       cmd_signa, cmd_signb;
  logic [1:0] cmd_asm;
  logic [3:0] alu_opa, alu_opb;
  logic       alu_signa, alu_signb;
  logic [1:0] alu_asm;
  logic [7:0] alu_opc;
  logic       alu_signc;
  logic       res_valid, res_ready;
  logic [7:0] res_opc;
  logic       res_sign, res_err;
  logic       busy;
  logic [7:0] op_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.SETTLE_CYCLES(S), .DIV_CODE(2'd3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
    .cmd_signa(cmd_signa), .cmd_signb(cmd_signb), .cmd_asm(cmd_asm),
    .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_signa(alu_signa), .alu_signb(alu_signb), .alu_asm(alu_asm),
    .alu_opc(alu_opc), .alu_signc(alu_signc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_opc(res_opc), .res_sign(res_sign), .res_err(res_err),
    .busy(busy), .op_count(op_count)
  );

  // Signed-magnitude ALU: 0 add, 1 sub, 2 mul, 3 div (truncating); div by 0 yields 0xEE.
  function automatic logic [8:0] alu_f(input logic [3:0] a, input logic sa,
                                       input logic [3:0] b, input logic sb,
                                       input logic [1:0] op);
    int x, y, r;
    x = sa ? -int'(a) : int'(a);
    y = sb ? -int'(b) : int'(b);
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: begin
        if (y == 0) return 9'h0EE;
        r = x / y;
      end
    endcase
    if (r < 0) return {1'b1, 8'(-r)};
    return {1'b0, 8'(r)};
  endfunction

  // Expected {err, sign, magnitude} for a command.
  function automatic logic [9:0] expect_res(input logic [3:0] a, input logic sa,
                                            input logic [3:0] b, input logic sb,
                                            input logic [1:0] op);
    if (DIV0_EN && op == 2'd3 && b == 4'd0) return 10'h200;
    return {1'b0, alu_f(a, sa, b, sb, op)};
  endfunction

  function automatic int latency(input logic [3:0] b, input logic [1:0] op);
    return (DIV0_EN && op == 2'd3 && b == 4'd0) ? 1 : int'(S);
  endfunction

  // ALU output is junk during the first cycle after its inputs change.
  logic [11:0] alu_cur, alu_prev;
  assign alu_cur = {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm};
  always @(posedge clk) alu_prev <= alu_cur;
  assign {alu_signc, alu_opc} = (alu_cur != alu_prev) ? 9'h15A
                              : alu_f(alu_opa, alu_signa, alu_opb, alu_signb, alu_asm);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] a, input logic sa,
                         input logic [3:0] b, input logic sb, input logic [1:0] op);
    cmd_valid = v; cmd_opa = a; cmd_signa = sa; cmd_opb = b; cmd_signb = sb; cmd_asm = op;
  endtask

  // Waits (bounded) for res_valid; returns edges waited.
  task automatic wait_valid(output int k);
    k = 0;
    while (!res_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  // One full operation with res_ready held high; called from an IDLE point.
  task automatic run_op(input logic [3:0] a, input logic sa, input logic [3:0] b,
                        input logic sb, input logic [1:0] op,
                        input logic [7:0] e_opc, input logic e_sign, input logic e_err);
    int k;
    chk("op_cmd_ready", cmd_ready, 1);
    set_cmd(1'b1, a, sa, b, sb, op);
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("op_alu_regs", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm}, {a, sa, b, sb, op});
    chk("op_busy", busy, 1);
    wait_valid(k);
    chk("op_latency", k, latency(b, op));
    chk("op_res_opc", res_opc, e_opc);
    chk("op_res_sign", res_sign, e_sign);
    chk("op_res_err", res_err, e_err);
    tick();
    exp_cnt++;
    chk("op_done_valid", res_valid, 0);
    chk("op_done_ready", cmd_ready, 1);
    chk("op_count", op_count, exp_cnt);
  endtask

  typedef struct {
    logic [3:0] opa;
    logic       sa;
    logic [3:0] opb;
    logic       sb;
    logic [1:0] op;
    logic [7:0] e_opc;
    logic       e_sign;
    logic       e_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [9:0] e;
    logic [3:0] a, b;
    logic       sa, sb;
    logic [1:0] op;
    logic [7:0] held;

    vecs[0] = '{4'd4,  1'b0, 4'd2,  1'b0, 2'd3, 8'd2,   1'b0, 1'b0};
    vecs[1] = '{4'd3,  1'b0, 4'd5,  1'b0, 2'd0, 8'd8,   1'b0, 1'b0};
    vecs[2] = '{4'd3,  1'b0, 4'd5,  1'b0, 2'd1, 8'd2,   1'b1, 1'b0};
    vecs[3] = '{4'd15, 1'b1, 4'd15, 1'b0, 2'd2, 8'd225, 1'b1, 1'b0};
    vecs[4] = '{4'd9,  1'b1, 4'd4,  1'b1, 2'd0, 8'd13,  1'b1, 1'b0};
    vecs[5] = '{4'd7,  1'b1, 4'd2,  1'b0, 2'd3, 8'd3,   1'b1, 1'b0};
    vecs[6] = '{4'd0,  1'b0, 4'd0,  1'b0, 2'd2, 8'd0,   1'b0, 1'b0};
`ifdef ALU_SEQ_DIV0_EN
    vecs[7] = '{4'd5,  1'b0, 4'd0,  1'b0, 2'd3, 8'h00,  1'b0, 1'b1};
`else
    vecs[7] = '{4'd5,  1'b0, 4'd0,  1'b0, 2'd3, 8'hEE,  1'b0, 1'b0};
`endif

    // Reset and idle
    rst = 1'b1;
    res_ready = 1'b0;
    set_cmd(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    exp_cnt = 8'd0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_regs", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm}, 0);
    chk("rst_res", {res_err, res_sign, res_opc}, 0);

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].opa, vecs[i].sa, vecs[i].opb, vecs[i].sb, vecs[i].op,
             vecs[i].e_opc, vecs[i].e_sign, vecs[i].e_err);

    // Backpressure with an ignored second command
    res_ready = 1'b0;
    set_cmd(1'b1, 4'd6, 1'b0, 4'd3, 1'b1, 2'd2);
    tick();
    cmd_valid = 1'b0;
    wait_valid(k);
    chk("bp_latency", k, S);
    chk("bp_res_opc", res_opc, 18);
    chk("bp_res_sign", res_sign, 1);
    held = res_opc;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) set_cmd(1'b1, 4'd9, 1'b0, 4'd4, 1'b0, 2'd1);
      tick();
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_opc", res_opc, held);
      chk("bp_alu_kept", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm},
          {4'd6, 1'b0, 4'd3, 1'b1, 2'd2});
    end
    res_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("bp_release_valid", res_valid, 0);
    chk("bp_release_ready", cmd_ready, 1);
    chk("bp_release_alu", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm},
        {4'd6, 1'b0, 4'd3, 1'b1, 2'd2});
    chk("bp_release_count", op_count, exp_cnt);
    tick();
    cmd_valid = 1'b0;
    chk("bp_second_alu", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm},
        {4'd9, 1'b0, 4'd4, 1'b0, 2'd1});
    chk("bp_second_busy", busy, 1);
    wait_valid(k);
    chk("bp_second_latency", k, S);
    chk("bp_second_opc", res_opc, 5);
    tick();
    exp_cnt++;
    chk("bp_second_count", op_count, exp_cnt);

    // Reset during DRIVE
    set_cmd(1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 2'd2);
    tick();
    cmd_valid = 1'b0;
    chk("mrst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_not_busy", busy, 0);
    chk("mrst_op_count", op_count, 0);
    chk("mrst_alu_regs", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_valid", res_valid, 0);
      tick();
    end

    // Randomized ops with random gaps, backpressure and ignored commands
    for (int n = 0; n < 60; n++) begin
      int  gap, lat;
      bit  done, rdy, vexp;
      gap = $urandom_range(0, 2);
      cmd_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("rnd_idle_ready", cmd_ready, 1);
      end
      a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
      sa = 1'($urandom); sb = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin op = 2'd3; b = 4'd0; end
      set_cmd(1'b1, a, sa, b, sb, op);
      res_ready = 1'($urandom);
      tick();
      e   = expect_res(a, sa, b, sb, op);
      lat = latency(b, op);
      done = 1'b0;
      k = 0;
      while (!done && k < 40) begin
        vexp = (k >= lat);
        chk("rnd_res_valid", res_valid, vexp);
        chk("rnd_alu_kept", {alu_opa, alu_signa, alu_opb, alu_signb, alu_asm}, {a, sa, b, sb, op});
        if (vexp) chk("rnd_result", {res_err, res_sign, res_opc}, e);
        rdy = 1'($urandom) || (k > lat + 8);
        if (vexp && rdy) set_cmd(1'b0, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
        else set_cmd(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
        res_ready = rdy;
        tick();
        k++;
        if (vexp && rdy) done = 1'b1;
      end
      if (!done) chk("rnd_timeout", 0, 1);
      exp_cnt++;
      chk("rnd_done_valid", res_valid, 0);
      chk("rnd_done_ready", cmd_ready, 1);
      chk("rnd_op_count", op_count, exp_cnt);
    end

    // op_count wrap after 256 back-to-back ops
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i);
      e = expect_res(a, 1'b0, 4'd1, 1'b0, 2'd0);
      run_op(a, 1'b0, 4'd1, 1'b0, 2'd0, e[7:0], e[8], e[9]);
      if (i == 254) chk("wrap_255", op_count, 255);
      if (i == 255) chk("wrap_zero", op_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
